// File: rtl/crate_packer_if.sv
// crate_packer_if: detector, clear and crate handoff signals of the crate packer
interface crate_packer_if #(
  parameter int BOXES_PER_CRATE = 4,
  parameter int DEPTH = 2,
  parameter int ID_W = 8
);
  logic det;
  logic clr;
  logic crate_ready;
  logic crate_valid;
  logic [ID_W-1:0] crate_id;
  logic [$clog2(BOXES_PER_CRATE)-1:0] box_cnt;
  logic [$clog2(DEPTH+1)-1:0] pending;
  logic overflow;
  modport master (
    output det, clr, crate_ready,
    input  crate_valid, crate_id, box_cnt, pending, overflow
  );
  modport slave (
    input  det, clr, crate_ready,
    output crate_valid, crate_id, box_cnt, pending, overflow
  );
endinterface

// File: rtl/crate_packer.sv
// crate_packer: groups detected boxes into crates and queues full crates for handoff
module crate_packer #(
  parameter int BOXES_PER_CRATE = 4,
  parameter int DEPTH = 2,
  parameter int ID_W = 8
) (
  input logic clk,
  input logic rst,
  crate_packer_if.slave bus
);
  localparam int BW = $clog2(BOXES_PER_CRATE);
  localparam int PW = $clog2(DEPTH + 1);
  logic handoff;
  logic boundary;
  logic accept;
  logic drop;
  logic [PW-1:0] pend_nxt;
  // A completing crate is kept if there is room, or if a handoff frees a slot this cycle
  always_comb begin
    handoff  = bus.crate_valid && bus.crate_ready;
    boundary = bus.det && bus.box_cnt == BW'(BOXES_PER_CRATE - 1);
    accept   = boundary && (bus.pending != PW'(DEPTH) || handoff);
    drop     = boundary && !accept;
    pend_nxt = bus.pending + PW'(accept) - PW'(handoff);
  end
  assign bus.crate_valid = bus.pending != '0;
  // Box counting, pending-crate occupancy, head sequence number and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.box_cnt  <= '0;
      bus.pending  <= '0;
      bus.crate_id <= '0;
      bus.overflow <= 1'b0;
    end else if (bus.clr) begin
      bus.box_cnt  <= '0;
      bus.pending  <= '0;
      bus.crate_id <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.box_cnt  <= boundary ? '0 : bus.box_cnt + BW'(bus.det);
      bus.pending  <= pend_nxt;
      bus.crate_id <= bus.crate_id + ID_W'(handoff);
      bus.overflow <= bus.overflow | drop;
    end
  end
endmodule

// File: tb/tb_crate_packer.sv
// tb_crate_packer: directed and randomized checks of crate_packer against a queue model
module tb_crate_packer;
  localparam int B = 4;
  localparam int D = 2;
  localparam int W = 8;
  logic clk;
  logic rst;
  int checks;
  int errors;
  int m_box;
  int m_next;
  bit m_ovf;
  int q[$];
  crate_packer_if #(.BOXES_PER_CRATE(B), .DEPTH(D), .ID_W(W)) bus ();
  crate_packer #(.BOXES_PER_CRATE(B), .DEPTH(D), .ID_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_box = 0;
    m_next = 0;
    m_ovf = 0;
    q.delete();
  endtask
  task automatic step(input logic d, input logic c, input logic r);
    @(negedge clk);
    bus.det = d;
    bus.clr = c;
    bus.crate_ready = r;
    if (c) begin
      model_reset();
    end else begin
      if (r && q.size() > 0) void'(q.pop_front());
      if (d) begin
        if (m_box == B - 1) begin
          m_box = 0;
          if (q.size() < D) begin
            q.push_back(m_next % 256);
            m_next++;
          end else m_ovf = 1;
        end else m_box++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #12;
    checks += 5;
    if (bus.box_cnt !== 2'd0) begin errors++; $display("FAIL reset_box got %0d exp 0", bus.box_cnt); end
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", bus.pending); end
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", bus.crate_id); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", bus.overflow); end
    if (bus.crate_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.crate_valid); end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask
  task automatic test_basic();
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      checks++;
      if (bus.box_cnt !== 2'((i + 1) % 4)) begin
        errors++; $display("FAIL basic_box%0d got %0d exp %0d", i, bus.box_cnt, (i + 1) % 4);
      end
      checks++;
      if (bus.crate_valid !== (i == 3)) begin
        errors++; $display("FAIL basic_valid%0d got %0b exp %0b", i, bus.crate_valid, i == 3);
      end
    end
    checks++;
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL basic_id0 got %0d exp 0", bus.crate_id); end
    step(0, 0, 1);
    checks += 3;
    if (bus.crate_id !== 8'd1) begin errors++; $display("FAIL basic_id1 got %0d exp 1", bus.crate_id); end
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL basic_pending got %0d exp 0", bus.pending); end
    if (bus.crate_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_end got %0b exp 0", bus.crate_valid); end
  endtask
  task automatic test_overflow();
    step(0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0);
      if (i % 4 == 0) begin
        checks++;
        if (bus.pending !== 2'(i == 4 ? 1 : 2)) begin
          errors++; $display("FAIL ovf_pending%0d got %0d exp %0d", i, bus.pending, i == 4 ? 1 : 2);
        end
        checks++;
        if (bus.overflow !== (i == 12)) begin
          errors++; $display("FAIL ovf_flag%0d got %0b exp %0b", i, bus.overflow, i == 12);
        end
      end
    end
    checks++;
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL ovf_id0 got %0d exp 0", bus.crate_id); end
    step(0, 0, 1);
    checks += 2;
    if (bus.crate_id !== 8'd1) begin errors++; $display("FAIL ovf_id1 got %0d exp 1", bus.crate_id); end
    if (bus.pending !== 2'd1) begin errors++; $display("FAIL ovf_pending_h1 got %0d exp 1", bus.pending); end
    step(0, 0, 1);
    checks += 3;
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL ovf_pending_h2 got %0d exp 0", bus.pending); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", bus.overflow); end
    if (bus.crate_id !== 8'd2) begin errors++; $display("FAIL ovf_id2 got %0d exp 2", bus.crate_id); end
  endtask
  task automatic test_simultaneous();
    step(0, 1, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0);
    checks++;
    if (bus.pending !== 2'd2) begin errors++; $display("FAIL sim_pre_pending got %0d exp 2", bus.pending); end
    step(1, 0, 1);
    checks += 4;
    if (bus.pending !== 2'd2) begin errors++; $display("FAIL sim_pending got %0d exp 2", bus.pending); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf got %0b exp 0", bus.overflow); end
    if (bus.crate_id !== 8'd1) begin errors++; $display("FAIL sim_id got %0d exp 1", bus.crate_id); end
    if (bus.box_cnt !== 2'd0) begin errors++; $display("FAIL sim_box got %0d exp 0", bus.box_cnt); end
  endtask
  task automatic test_wrap();
    step(0, 1, 0);
    for (int i = 0; i < 255 * B; i++) step(1, 0, 1);
    step(0, 0, 1);
    checks++;
    if (bus.crate_id !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d exp 255", bus.crate_id); end
    for (int i = 0; i < B; i++) step(1, 0, 0);
    checks += 2;
    if (bus.crate_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b exp 1", bus.crate_valid); end
    if (bus.crate_id !== 8'd255) begin errors++; $display("FAIL wrap_hold got %0d exp 255", bus.crate_id); end
    step(0, 0, 1);
    checks += 2;
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL wrap_id got %0d exp 0", bus.crate_id); end
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL wrap_pending got %0d exp 0", bus.pending); end
  endtask
  task automatic test_async_reset();
    step(0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    @(negedge clk);
    bus.det = 0;
    bus.clr = 0;
    bus.crate_ready = 0;
    #2 rst = 1;
    #1;
    checks += 5;
    if (bus.box_cnt !== 2'd0) begin errors++; $display("FAIL arst_box got %0d exp 0", bus.box_cnt); end
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL arst_pending got %0d exp 0", bus.pending); end
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL arst_id got %0d exp 0", bus.crate_id); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %0b exp 0", bus.overflow); end
    if (bus.crate_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b exp 0", bus.crate_valid); end
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    checks += 2;
    if (bus.crate_valid !== 1'b1) begin errors++; $display("FAIL arst_after_valid got %0b exp 1", bus.crate_valid); end
    if (bus.crate_id !== 8'd0) begin errors++; $display("FAIL arst_after_id got %0d exp 0", bus.crate_id); end
  endtask
  task automatic test_clr();
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 0);
    checks += 4;
    if (bus.box_cnt !== 2'd0) begin errors++; $display("FAIL clr_box got %0d exp 0", bus.box_cnt); end
    if (bus.pending !== 2'd0) begin errors++; $display("FAIL clr_pending got %0d exp 0", bus.pending); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b exp 0", bus.overflow); end
    if (bus.crate_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b exp 0", bus.crate_valid); end
  endtask
  task automatic test_random();
    int eid;
    step(0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 10) < 7, ($urandom % 100) == 0, ($urandom % 10) < 3);
      eid = q.size() > 0 ? q[0] : m_next % 256;
      checks += 5;
      if (bus.box_cnt !== 2'(m_box)) begin errors++; $display("FAIL rnd_box @%0d got %0d exp %0d", n, bus.box_cnt, m_box); end
      if (bus.pending !== 2'(q.size())) begin errors++; $display("FAIL rnd_pending @%0d got %0d exp %0d", n, bus.pending, q.size()); end
      if (bus.crate_id !== 8'(eid)) begin errors++; $display("FAIL rnd_id @%0d got %0d exp %0d", n, bus.crate_id, eid); end
      if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf @%0d got %0b exp %0b", n, bus.overflow, m_ovf); end
      if (bus.crate_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid @%0d got %0b exp %0b", n, bus.crate_valid, q.size() > 0); end
    end
  endtask
  initial begin
    clk = 0;
    rst = 1;
    checks = 0;
    errors = 0;
    bus.det = 0;
    bus.clr = 0;
    bus.crate_ready = 0;
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
